// File: rtl/anton_pm_sequencer.sv
// Controller for a nibble-serial add/sub accumulator datapath: arbitrates two
// operand requesters into a single buffer and sequences destructive 24-bit readback.
module anton_pm_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_data0,
  input  logic [7:0]  req_data1,
  output logic [1:0]  req_grant,
  input  logic        rd_req,
  output logic        rd_valid,
  output logic [23:0] rd_data,
  output logic        dp_reset,
  output logic        dp_read,
  output logic [3:0]  dp_nibble,
  input  logic [7:0]  dp_result,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ph_q, ph_d;
  logic        buf_valid_q, buf_valid_d;
  logic        buf_op_q, buf_op_d;
  logic [7:0]  buf_data_q, buf_data_d;
  logic        buf_armed_q, buf_armed_d;
  logic        prio_q, prio_d;
  logic [23:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  logic        read_phase;
  logic        low_hit, high_hit;
  logic        grant_ok, gnt_any, gnt_idx;
  logic [1:0]  gnt_vec;
  logic [3:0]  nibble;

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    buf_valid_d = buf_valid_q;
    buf_op_d    = buf_op_q;
    buf_data_d  = buf_data_q;
    buf_armed_d = buf_armed_q;
    prio_d      = prio_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    gnt_any     = 1'b0;
    gnt_idx     = 1'b0;
    gnt_vec     = 2'b00;
    nibble      = 4'h0;

    read_phase = (state_q == RD0) || (state_q == RD1) || (state_q == RD2);
    low_hit    = buf_valid_q && (ph_q == {buf_op_q, 1'b0}) && !read_phase;
    high_hit   = buf_valid_q && buf_armed_q && (ph_q == {buf_op_q, 1'b1}) && !read_phase;

    // The datapath adds or subtracts whatever nibble it sees, so idle slots must see zero.
    if (buf_valid_q && (ph_q == {buf_op_q, 1'b0}))
      nibble = buf_data_q[3:0];
    else if (buf_valid_q && buf_armed_q && (ph_q == {buf_op_q, 1'b1}))
      nibble = buf_data_q[7:4];

    if (!read_phase)
      ph_d = ph_q + 2'd1;

    if (low_hit)
      buf_armed_d = 1'b1;
    if (high_hit) begin
      buf_valid_d = 1'b0;
      buf_armed_d = 1'b0;
    end

    grant_ok = (state_q == IDLE) && (!buf_valid_q || high_hit) && !rd_req;
    if (grant_ok) begin
      if (req_valid[prio_q]) begin
        gnt_any = 1'b1;
        gnt_idx = prio_q;
      end else if (req_valid[~prio_q]) begin
        gnt_any = 1'b1;
        gnt_idx = ~prio_q;
      end
    end

    if (gnt_any) begin
      gnt_vec[gnt_idx] = 1'b1;
      buf_valid_d      = 1'b1;
      buf_armed_d      = 1'b0;
      buf_op_d         = req_op[gnt_idx];
      buf_data_d       = gnt_idx ? req_data1 : req_data0;
      prio_d           = ~gnt_idx;
    end

    // Readback walks the accumulator out a byte at a time, lowest byte first.
    case (state_q)
      IDLE: if (rd_req && !buf_valid_q) state_d = RD0;
      RD0:  state_d = RD1;
      RD1: begin
        state_d         = RD2;
        rd_data_d[7:0]  = dp_result;
      end
      RD2: begin
        state_d         = RD3;
        rd_data_d[15:8] = dp_result;
      end
      RD3: begin
        state_d          = IDLE;
        rd_data_d[23:16] = dp_result;
        rd_valid_d       = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ph_q        <= 2'd0;
      buf_valid_q <= 1'b0;
      buf_op_q    <= 1'b0;
      buf_data_q  <= 8'h00;
      buf_armed_q <= 1'b0;
      prio_q      <= 1'b0;
      rd_data_q   <= 24'h0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      buf_valid_q <= buf_valid_d;
      buf_op_q    <= buf_op_d;
      buf_data_q  <= buf_data_d;
      buf_armed_q <= buf_armed_d;
      prio_q      <= prio_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign dp_reset  = reset;
  assign dp_read   = read_phase && !reset;
  assign dp_nibble = reset ? 4'h0 : nibble;
  assign req_grant = reset ? 2'b00 : gnt_vec;
  assign busy      = !reset && (buf_valid_q || (state_q != IDLE));
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_anton_pm_sequencer.sv
// Bench for anton_pm_sequencer: behavioural accumulator datapath plus scoreboards
// for expected grants and readback values.
module tb_anton_pm_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_op = 2'b00;
  logic [7:0]  req_data0 = 8'h00;
  logic [7:0]  req_data1 = 8'h00;
  logic [1:0]  req_grant;
  logic        rd_req = 1'b0;
  logic        rd_valid;
  logic [23:0] rd_data;
  logic        dp_reset;
  logic        dp_read;
  logic [3:0]  dp_nibble;
  logic [7:0]  dp_result;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0]  grant_q[$];
  logic [23:0] rd_exp_q[$];

  logic [23:0] acc;
  logic [1:0]  dp_ph;

  anton_pm_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_grant(req_grant),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .dp_reset(dp_reset), .dp_read(dp_read), .dp_nibble(dp_nibble),
    .dp_result(dp_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath model: slots 0/1 add low/high nibble, slots 2/3 subtract; a read shifts out bytes.
  always @(posedge clk) begin
    if (dp_reset) begin
      acc       <= 24'h0;
      dp_ph     <= 2'd0;
      dp_result <= 8'h00;
    end else if (dp_read) begin
      dp_result <= acc[7:0];
      acc       <= acc >> 8;
    end else begin
      case (dp_ph)
        2'd0: acc <= acc + {20'h0, dp_nibble};
        2'd1: acc <= acc + {16'h0, dp_nibble, 4'h0};
        2'd2: acc <= acc - {20'h0, dp_nibble};
        default: acc <= acc - {16'h0, dp_nibble, 4'h0};
      endcase
      dp_ph <= dp_ph + 2'd1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumers: every grant and every rd_valid pulse must match a queued expectation.
  always @(negedge clk) begin
    if (req_grant != 2'b00) begin
      if (grant_q.size() == 0) checkOutput("grant_unexpected", {30'h0, req_grant}, 32'h0);
      else checkOutput("grant", {30'h0, req_grant}, {30'h0, grant_q.pop_front()});
    end
    if (rd_valid) begin
      if (rd_exp_q.size() == 0) checkOutput("rd_valid_unexpected", {8'h0, rd_data}, 32'hFFFF_FFFF);
      else checkOutput("rd_data", {8'h0, rd_data}, {8'h0, rd_exp_q.pop_front()});
    end
  end

  task automatic resetDut();
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 2'b11; rd_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_dp_reset", {31'h0, dp_reset}, 32'h1);
    checkOutput("rst_dp_read", {31'h0, dp_read}, 32'h0);
    checkOutput("rst_dp_nibble", {28'h0, dp_nibble}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_grant", {30'h0, req_grant}, 32'h0);
    checkOutput("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    checkOutput("rst_rd_data", {8'h0, rd_data}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 2'b00; rd_req = 1'b0;
  endtask

  task automatic applyStimulus(input int idx, input logic op, input logic [7:0] data);
    bit seen = 0;
    grant_q.push_back(idx == 0 ? 2'b01 : 2'b10);
    @(posedge clk); #1;
    req_op[idx] = op;
    if (idx == 0) req_data0 = data; else req_data1 = data;
    req_valid[idx] = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (req_grant[idx]) seen = 1;
    end
    checkOutput("grant_wait", {31'h0, seen}, 32'h1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic startRead(input bit push, input logic [23:0] exp);
    if (push) rd_exp_q.push_back(exp);
    rd_req = 1'b1;
  endtask

  task automatic finishRead();
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (dp_read) seen = 1;
    end
    checkOutput("read_start_wait", {31'h0, seen}, 32'h1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rd_valid) seen = 1;
    end
    checkOutput("rd_valid_wait", {31'h0, seen}, 32'h1);
    @(negedge clk);
    checkOutput("rd_valid_pulse", {31'h0, rd_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int grants;

    // Single add then readback, then a second destructive read.
    resetDut();
    applyStimulus(0, 1'b0, 8'h35);
    startRead(1, 24'h000035);
    finishRead();
    @(posedge clk); #1;
    startRead(1, 24'h000000);
    finishRead();

    // Subtract granted in the phase-0 cycle; nibble must stay zero through the add slots.
    resetDut();
    grant_q.push_back(2'b10);
    req_valid = 2'b10; req_op = 2'b10; req_data1 = 8'h01;
    @(negedge clk);
    checkOutput("sub_nib_ph0", {28'h0, dp_nibble}, 32'h0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("sub_nib_ph1", {28'h0, dp_nibble}, 32'h0);
    @(negedge clk);
    checkOutput("sub_nib_ph2", {28'h0, dp_nibble}, 32'h1);
    @(negedge clk);
    checkOutput("sub_nib_ph3", {28'h0, dp_nibble}, 32'h0);
    @(posedge clk); #1;
    startRead(1, 24'hFFFFFF);
    finishRead();

    // Both requesters always valid: grants must alternate, four operations total.
    resetDut();
    grant_q.push_back(2'b01); grant_q.push_back(2'b10);
    grant_q.push_back(2'b01); grant_q.push_back(2'b10);
    req_op = 2'b10; req_data0 = 8'h10; req_data1 = 8'h04; req_valid = 2'b11;
    grants = 0;
    for (int i = 0; i < 100 && grants < 4; i++) begin
      @(negedge clk);
      if (req_grant != 2'b00) grants++;
    end
    checkOutput("rr_grant_count", grants, 4);
    @(posedge clk); #1;
    req_valid = 2'b00;
    startRead(1, 24'h000018);
    finishRead();

    // Read requested while an armed add 0xFF is in the buffer: read waits for the buffer.
    resetDut();
    grant_q.push_back(2'b01);
    req_valid = 2'b01; req_op = 2'b00; req_data0 = 8'hFF;
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("ff_low_nib", {28'h0, dp_nibble}, 32'hF);
    @(posedge clk); #1;
    startRead(1, 24'h0000FF);
    @(negedge clk);
    checkOutput("ff_armed_dp_read", {31'h0, dp_read}, 32'h0);
    checkOutput("ff_high_nib", {28'h0, dp_nibble}, 32'hF);
    checkOutput("ff_armed_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    checkOutput("ff_clear_dp_read", {31'h0, dp_read}, 32'h0);
    checkOutput("ff_clear_nib", {28'h0, dp_nibble}, 32'h0);
    finishRead();

    // Reset in RD1 discards the partial readback and previous rd_data.
    applyStimulus(0, 1'b0, 8'h35);
    startRead(0, 24'h0);
    begin
      bit seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        if (dp_read) seen = 1;
      end
      checkOutput("rd1_reset_start", {31'h0, seen}, 32'h1);
    end
    @(posedge clk); #1;
    reset = 1'b1; rd_req = 1'b0;
    @(negedge clk);
    checkOutput("rd1_reset_dp_read", {31'h0, dp_read}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rd1_after_rd_data", {8'h0, rd_data}, 32'h0);
    checkOutput("rd1_after_dp_read", {31'h0, dp_read}, 32'h0);
    checkOutput("rd1_after_busy", {31'h0, busy}, 32'h0);
    repeat (6) begin
      @(negedge clk);
      checkOutput("rd1_no_rd_valid", {31'h0, rd_valid}, 32'h0);
    end

    checkOutput("grant_queue_empty", grant_q.size(), 0);
    checkOutput("rd_queue_empty", rd_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/anton_pm_sequencer.md
ANTON_PM_SEQUENCER -- requirements
Module: anton_pm_sequencer

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 req_valid  in  2  per-requester operand request; held until granted.
REQ-004 req_op  in  2  per-requester operation; 0 = add, 1 = subtract.
REQ-005 req_data0, req_data1  in  8 each  operands of requester 0 and requester 1.
REQ-006 req_grant  out  2  one-cycle pulse; operand accepted on that edge.
REQ-007 rd_req  in  1  level; request destructive 24-bit accumulator readback.
REQ-008 rd_valid  out  1  one-cycle pulse; rd_data is updated and valid.
REQ-009 rd_data  out  24  last readback value; bits [7:0] hold the first byte received.
REQ-010 dp_reset  out  1  datapath reset; equals reset combinationally.
REQ-011 dp_read  out  1  datapath read strobe.
REQ-012 dp_nibble  out  4  datapath nibble bus.
REQ-013 dp_result  in  8  datapath registered byte output.
REQ-014 busy  out  1  high while the operand buffer is valid or a read is active.

Function
REQ-015 Phase mirror ph[1:0] SHALL track the datapath: +1 (wrapping) on every edge with dp_read=0 and reset=0; held while dp_read=1.
- ph[1] = slot kind (0 add, 1 sub); ph[0] = nibble (0 low, 1 high).
REQ-016 Single operand buffer SHALL hold {valid, op, data, armed}.
REQ-017 dp_nibble SHALL be combinational and driven from the operand buffer.
- data[3:0] when buffer valid and ph=={op,0}.
- data[7:4] when buffer valid, armed, and ph=={op,1}.
- otherwise 4'h0, so unused slots add or subtract zero.
REQ-018 armed SHALL set on the edge consuming the low nibble (ph=={op,0}, dp_read=0).
- buffer valid and armed SHALL clear on the edge consuming the high nibble.
- a buffer loaded while ph=={op,1} SHALL wait for the next {op,0}.
REQ-019 Add/sub latency from grant edge to accumulator update SHALL be 2 to 5 edges, set by phase alignment.
REQ-020 Grants: at most one per edge, only when all of the following hold.
- controller state IDLE.
- buffer empty, or clearing on the same edge.
- rd_req=0.
REQ-021 Arbitration SHALL be round-robin: after reset requester 0 has priority; priority flips to the other requester after each grant.
REQ-022 The granted requester's op and data SHALL be loaded into the buffer on the grant edge.
REQ-023 Read FSM states SHALL be IDLE, RD0, RD1, RD2, RD3.
- IDLE->RD0 when rd_req=1 and buffer empty.
- RD0->RD1->RD2->RD3->IDLE unconditionally.
REQ-024 dp_read SHALL be 1 in RD0, RD1 and RD2 only.
REQ-025 Byte capture from dp_result on the edge leaving each state:
- RD1 -> rd_data[7:0].
- RD2 -> rd_data[15:8].
- RD3 -> rd_data[23:16].
REQ-026 rd_valid SHALL be high for exactly the one cycle after the RD3 edge.
REQ-027 rd_data SHALL hold its value until the next RD1/RD2/RD3 capture edges.
REQ-028 A read leaves the datapath accumulator at zero; the controller SHALL NOT restore it.
REQ-029 A pending read SHALL block new grants but SHALL NOT abort an operand in the buffer.
- Read starts only after the buffer clears.
REQ-030 In RD3 dp_read=0; ph SHALL advance, and dp_nibble SHALL be 0 because the buffer is empty.
REQ-031 Simultaneous rd_req and req_valid in IDLE with buffer empty: the read SHALL win.
REQ-032 Arithmetic is performed only by the datapath, modulo 2^24; the controller SHALL NOT modify operands.

Reset
REQ-033 When reset=1, the following SHALL be cleared on the clock edge.
- ph=0, buffer valid=0, armed=0.
- FSM=IDLE, round-robin priority = requester 0.
- rd_data=0, rd_valid=0, req_grant=0.
REQ-034 While reset=1: dp_reset=1, dp_read=0, dp_nibble=0, busy=0.
REQ-035 Reset mid-operation or mid-read SHALL discard the operand and partial rd_data with no further grant or rd_valid.

Verification
REQ-036 Reset, req0 add 0x35, then rd_req -> one grant to req0; rd_valid once; rd_data=0x000035.
REQ-037 After reset, req1 sub 0x01 granted at ph=0, then read -> dp_nibble 0 during the add slot; rd_data=0xFFFFFF.
REQ-038 Both requesters valid every cycle (req0 add 0x10, req1 sub 0x04), four operations total, then read -> grants alternate 0,1,0,1; rd_data=0x000018.
REQ-039 rd_req asserted while the buffer holds add 0xFF, armed -> dp_read stays 0 until the buffer clears; rd_data=0x0000FF.
REQ-040 A second read right after REQ-036 -> rd_data=0x000000 (destructive read).
REQ-041 reset asserted in RD1 -> no rd_valid; rd_data=0; dp_read=0 on the next cycle.
